// File: rtl/bg_row_arbiter.sv
// bg_row_arbiter
//   Arbitrates a single-port background row RAM between a CPU PIO write path
//   and a video read path. The CPU announces a row write by moving
//   background_wr from IDLE_CODE to a row index; the row/bitmap pair is held
//   in a one-entry pending buffer (latest wins) and committed to RAM when the
//   arbiter is idle. Video reads take two cycles (address, then data) and
//   always win over a pending commit.
//
//   Optional feature: define BG_VBLANK_ONLY_EN to restrict commits to cycles
//   where vblank is high.
//
// Ports
//   clk_clk          : system clock, rising edge
//   reset_reset      : asynchronous active-high reset
//   background_wr    : CPU row index, or IDLE_CODE for "no write"
//   background_data  : CPU row bitmap (1 = wall)
//   vblank           : video blanking level
//   rd_req / rd_row  : one-cycle read request and row index
//   rd_valid/rd_data : read result, valid for one cycle
//   ram_*            : single-port RAM, one-cycle read latency
//   refresh_image    : tells the CPU a blanking interval has started
//   wr_overflow      : sticky, a pending write was overwritten before commit
//   busy             : a write is pending or being committed

module bg_row_arbiter #(
    parameter int unsigned ROWS      = 31,
    parameter logic [4:0]  IDLE_CODE = 5'h1F
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [4:0]  background_wr,
    input  logic [31:0] background_data,
    input  logic        vblank,
    input  logic        rd_req,
    input  logic [4:0]  rd_row,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [4:0]  ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        refresh_image,
    output logic        wr_overflow,
    output logic        busy
);

    localparam int unsigned ROW_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD1  = 2'd1,
        S_RD2  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    prev_wr_q, prev_wr_d;
    logic                vblank_q, vblank_d;
    wr_entry_t           pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ROW_W-1:0]    ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                refresh_q, refresh_d;
    logic                ovf_q, ovf_d;

    logic                req_det_c;
    logic                commit_ok_c;
    logic                commit_c;

    // State and output registers
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            prev_wr_q   <= IDLE_CODE;
            vblank_q    <= 1'b0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            refresh_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_wr_q   <= prev_wr_d;
            vblank_q    <= vblank_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            refresh_q   <= refresh_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, pending buffer and output decode
    always_comb begin
        state_d     = state_q;
        prev_wr_d   = background_wr;
        vblank_d    = vblank;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        refresh_d   = refresh_q;
        ovf_d       = ovf_q;

        // A write is only announced by leaving IDLE_CODE for a legal row.
        req_det_c = (prev_wr_q == IDLE_CODE) && (32'(background_wr) < ROWS);

`ifdef BG_VBLANK_ONLY_EN
        commit_ok_c = pend_vld_q && vblank;
`else
        commit_ok_c = pend_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d = S_RD1;
                end else if (commit_ok_c) begin
                    state_d = S_WR;
                end
            end
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_IDLE;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        commit_c = (state_q == S_IDLE) && (state_d == S_WR);

        // RAM port is loaded on entry so it is stable for the whole RD1/WR cycle.
        if (state_d == S_RD1) begin
            ram_addr_d = rd_row;
        end
        if (commit_c) begin
            ram_addr_d  = pend_q.row;
            ram_wdata_d = pend_q.data;
        end
        ram_we_d   = (state_d == S_WR);
        rd_valid_d = (state_d == S_RD2);

        // Hold the last read result once rd_valid drops.
        if (rd_valid_q) begin
            rd_data_d = ram_rdata;
        end

        // The entry leaves the buffer when its commit is scheduled; a request in
        // that same cycle refills it without losing anything.
        if (commit_c) begin
            pend_vld_d = 1'b0;
        end
        if (req_det_c) begin
            pend_vld_d = 1'b1;
            pend_d.row  = background_wr;
            pend_d.data = background_data;
            if (pend_vld_q && !commit_c) begin
                ovf_d = 1'b1;
            end
        end

        busy_d = pend_vld_d || (state_d == S_WR);

        if (vblank && !vblank_q) begin
            refresh_d = 1'b1;
        end
        if ((!vblank && vblank_q) || req_det_c) begin
            refresh_d = 1'b0;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_we        = ram_we_q;
    assign ram_wdata     = ram_wdata_q;
    assign rd_valid      = rd_valid_q;
    // RAM data arrives in RD2 itself, so it is passed straight through there.
    assign rd_data       = rd_valid_q ? ram_rdata : rd_data_q;
    assign busy          = busy_q;
    assign refresh_image = refresh_q;
    assign wr_overflow   = ovf_q;

endmodule

// File: tb/tb_bg_row_arbiter.sv
// Testbench for bg_row_arbiter: directed stimulus, a transaction-level
// reference model checked every cycle, and literal expectations for the
// key scenarios.

module tb_bg_row_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  background_wr;
    logic [31:0] background_data;
    logic        vblank;
    logic        rd_req;
    logic [4:0]  rd_row;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [4:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        refresh_image;
    logic        wr_overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bg_row_arbiter dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .background_wr   (background_wr),
        .background_data (background_data),
        .vblank          (vblank),
        .rd_req          (rd_req),
        .rd_row          (rd_row),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .refresh_image   (refresh_image),
        .wr_overflow     (wr_overflow),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM with one-cycle read latency
    logic [31:0] mem [32];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (rst && !mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 7) ? 32'h1234_5678 : 32'h0;
            mem_loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: pending slot, read phase counter, write in flight
    localparam int M_ROWS = 31;
    logic [4:0]  m_prev_wr;
    logic        m_prev_vb;
    logic        m_pend;
    logic [4:0]  m_prow;
    logic [31:0] m_pdata;
    int          m_rd_phase;
    logic [4:0]  m_rd_row;
    logic        m_wr_now;
    logic [4:0]  m_wr_row;
    logic [31:0] m_wr_data;
    logic        m_refresh;
    logic        m_ovf;
    logic [31:0] sh [32];
    logic        sh_loaded = 1'b0;
    logic        m_det, m_idle, m_start_rd, m_start_wr, m_elig;

    always_comb begin
        m_det      = (m_prev_wr == 5'h1F) && (int'(background_wr) < M_ROWS);
        m_idle     = (m_rd_phase == 0) && !m_wr_now;
`ifdef BG_VBLANK_ONLY_EN
        m_elig     = vblank;
`else
        m_elig     = 1'b1;
`endif
        m_start_rd = m_idle && rd_req;
        m_start_wr = m_idle && !rd_req && m_pend && m_elig;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (!sh_loaded) begin
                for (int i = 0; i < 32; i++) sh[i] <= (i == 7) ? 32'h1234_5678 : 32'h0;
                sh_loaded <= 1'b1;
            end
            m_prev_wr  <= 5'h1F;
            m_prev_vb  <= 1'b0;
            m_pend     <= 1'b0;
            m_prow     <= 5'h0;
            m_pdata    <= 32'h0;
            m_rd_phase <= 0;
            m_rd_row   <= 5'h0;
            m_wr_now   <= 1'b0;
            m_wr_row   <= 5'h0;
            m_wr_data  <= 32'h0;
            m_refresh  <= 1'b0;
            m_ovf      <= 1'b0;
        end else begin
            if (m_wr_now) sh[m_wr_row] <= m_wr_data;
            if (m_rd_phase == 1)      m_rd_phase <= 2;
            else if (m_rd_phase == 2) m_rd_phase <= 0;
            else if (m_start_rd) begin
                m_rd_phase <= 1;
                m_rd_row   <= rd_row;
            end
            m_wr_now <= m_start_wr;
            if (m_start_wr) begin
                m_wr_row  <= m_prow;
                m_wr_data <= m_pdata;
            end
            if (m_det) begin
                m_pend  <= 1'b1;
                m_prow  <= background_wr;
                m_pdata <= background_data;
                if (m_pend && !m_start_wr) m_ovf <= 1'b1;
            end else if (m_start_wr) begin
                m_pend <= 1'b0;
            end
            if (m_det)                       m_refresh <= 1'b0;
            else if (vblank && !m_prev_vb)   m_refresh <= 1'b1;
            else if (!vblank && m_prev_vb)   m_refresh <= 1'b0;
            m_prev_wr <= background_wr;
            m_prev_vb <= vblank;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cmp rd_valid", 32'(rd_valid), 32'(m_rd_phase == 2));
        chk("cmp ram_we", 32'(ram_we), 32'(m_wr_now));
        chk("cmp busy", 32'(busy), 32'(m_pend || m_wr_now));
        chk("cmp refresh_image", 32'(refresh_image), 32'(m_refresh));
        chk("cmp wr_overflow", 32'(wr_overflow), 32'(m_ovf));
        if (m_wr_now) begin
            chk("cmp wr ram_addr", 32'(ram_addr), 32'(m_wr_row));
            chk("cmp ram_wdata", ram_wdata, m_wr_data);
        end
        if (m_rd_phase == 1) chk("cmp rd ram_addr", 32'(ram_addr), 32'(m_rd_row));
        if (m_rd_phase == 2) chk("cmp rd_data", rd_data, sh[m_rd_row]);
    end

    // Apply inputs for one cycle; returns 1 ns after the next rising edge
    task automatic step(input logic [4:0] bg, input logic [31:0] d, input logic rq,
                        input logic [4:0] rr, input logic vb);
        background_wr   = bg;
        background_data = d;
        rd_req          = rq;
        rd_row          = rr;
        vblank          = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ram_we"}, 32'(ram_we), 32'h0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " refresh"}, 32'(refresh_image), 32'h0);
        chk({tag, " overflow"}, 32'(wr_overflow), 32'h0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, " ram_wdata"}, ram_wdata, 32'h0);
        chk({tag, " rd_data"}, rd_data, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        background_wr = 5'h1F; background_data = 32'h0;
        vblank = 1'b0; rd_req = 1'b0; rd_row = 5'h0;
        for (int i = 0; i < 3; i++) step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk_all_zero("reset");
        rst = 1'b0;
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);

        // vblank rise sets refresh_image
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("vb rise refresh", 32'(refresh_image), 32'h1);

        // Simple write 1F->05
        step(5'h05, 32'hF00F_000F, 1'b0, 5'h0, 1'b1);
        chk("wr busy", 32'(busy), 32'h1);
        chk("wr clears refresh", 32'(refresh_image), 32'h0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("wr ram_we", 32'(ram_we), 32'h1);
        chk("wr ram_addr", 32'(ram_addr), 32'h5);
        chk("wr ram_wdata", ram_wdata, 32'hF00F_000F);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("wr busy done", 32'(busy), 32'h0);
        chk("wr we done", 32'(ram_we), 32'h0);

        // Read row 7
        step(5'h1F, 32'h0, 1'b1, 5'h07, 1'b1);
        chk("rd1 valid", 32'(rd_valid), 32'h0);
        chk("rd1 addr", 32'(ram_addr), 32'h7);
        chk("rd1 we", 32'(ram_we), 32'h0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("rd2 valid", 32'(rd_valid), 32'h1);
        chk("rd2 data", rd_data, 32'h1234_5678);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("rd done valid", 32'(rd_valid), 32'h0);

        // Write request and read in the same IDLE cycle: read first
        step(5'h0C, 32'hA5A5_5A5A, 1'b1, 5'h05, 1'b1);
        chk("coll rd1 we", 32'(ram_we), 32'h0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("coll rd2 valid", 32'(rd_valid), 32'h1);
        chk("coll rd2 data", rd_data, 32'hF00F_000F);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("coll idle we", 32'(ram_we), 32'h0);
        chk("coll idle busy", 32'(busy), 32'h1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("coll wr we", 32'(ram_we), 32'h1);
        chk("coll wr addr", 32'(ram_addr), 32'h0C);
        chk("coll wr data", ram_wdata, 32'hA5A5_5A5A);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);

        // Overwrite while a read blocks the commit
        step(5'h03, 32'h1111_1111, 1'b1, 5'h02, 1'b1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        step(5'h09, 32'h2222_2222, 1'b0, 5'h0, 1'b1);
        chk("ovf set", 32'(wr_overflow), 32'h1);
        chk("ovf busy", 32'(busy), 32'h1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("ovf wr we", 32'(ram_we), 32'h1);
        chk("ovf wr addr", 32'(ram_addr), 32'h09);
        chk("ovf wr data", ram_wdata, 32'h2222_2222);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("ovf row3 untouched", mem[3], 32'h0);
        chk("ovf sticky", 32'(wr_overflow), 32'h1);

        // Highest legal row, then a non-idle transition that must be ignored
        step(5'h1E, 32'hDEAD_BEEF, 1'b0, 5'h0, 1'b1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("row30 addr", 32'(ram_addr), 32'h1E);
        chk("row30 we", 32'(ram_we), 32'h1);
        step(5'h04, 32'h4444_4444, 1'b0, 5'h0, 1'b1);
        step(5'h06, 32'h6666_6666, 1'b0, 5'h0, 1'b1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("row4 written", mem[4], 32'h4444_4444);
        chk("row6 ignored", mem[6], 32'h0);

        // vblank fall/rise/fall on refresh_image
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk("vb fall refresh", 32'(refresh_image), 32'h0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("vb rise2 refresh", 32'(refresh_image), 32'h1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("vb hold refresh", 32'(refresh_image), 32'h1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk("vb fall2 refresh", 32'(refresh_image), 32'h0);

        // Reset while a write is pending
        step(5'h07, 32'hCAFE_F00D, 1'b0, 5'h0, 1'b0);
        chk("rst pend busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk("midrst hold we", 32'(ram_we), 32'h0);
        rst = 1'b0;
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk("postrst we", 32'(ram_we), 32'h0);
        chk("postrst busy", 32'(busy), 32'h0);
        chk("postrst row7 kept", mem[7], 32'h1234_5678);

        // Two requests with vblank low
        step(5'h03, 32'h3333_3333, 1'b0, 5'h0, 1'b0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        step(5'h09, 32'h9999_9999, 1'b0, 5'h0, 1'b0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
`ifdef BG_VBLANK_ONLY_EN
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk("vbo wait we", 32'(ram_we), 32'h0);
        chk("vbo wait busy", 32'(busy), 32'h1);
        chk("vbo ovf", 32'(wr_overflow), 32'h1);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("vbo wr we", 32'(ram_we), 32'h1);
        chk("vbo wr addr", 32'(ram_addr), 32'h09);
        chk("vbo wr data", ram_wdata, 32'h9999_9999);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b1);
        chk("vbo row3 dropped", mem[3], 32'h0);
`else
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        chk("any row3 written", mem[3], 32'h3333_3333);
        chk("any row9 written", mem[9], 32'h9999_9999);
        chk("any no ovf", 32'(wr_overflow), 32'h0);
`endif
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);
        step(5'h1F, 32'h0, 1'b0, 5'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bg_row_arbiter.md
BG_ROW_ARBITER -- requirements
Module: bg_row_arbiter

Interface
REQ-001 SHALL have parameter ROWS, default 31, number of background rows held in the row RAM.
REQ-002 SHALL have parameter IDLE_CODE, default 5'h1F, value of background_wr meaning "no write".
REQ-003 SHALL have port clk_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port background_wr  in  5  CPU PIO row index, or IDLE_CODE.
REQ-006 SHALL have port background_data  in  32  CPU PIO row bitmap (1 = wall).
REQ-007 SHALL have port vblank  in  1  video blanking interval, level.
REQ-008 SHALL have ports rd_req  in  1 (one-cycle read pulse), rd_row  in  5, rd_valid  out  1, rd_data  out  32.
REQ-009 SHALL have ports ram_addr  out  5, ram_we  out  1, ram_wdata  out  32, ram_rdata  in  32 (single-port RAM, 1-cycle read latency).
REQ-010 SHALL have ports refresh_image  out  1 (to CPU PIO), wr_overflow  out  1 (sticky), busy  out  1 (write pending).

Function
REQ-011 SHALL detect a write request in cycle N when background_wr was IDLE_CODE in N-1 and is below ROWS in N; other transitions ignored.
REQ-012 SHALL capture row and background_data into a 1-entry pending buffer at the edge ending cycle N; busy high from N+1 until commit.
REQ-013 SHALL, on a new request while pending, overwrite the buffer (latest wins) and set wr_overflow.
REQ-014 SHALL run FSM IDLE, RD1, RD2, WR: IDLE->RD1 on rd_req; RD1->RD2; RD2->IDLE; IDLE->WR on commit; WR->IDLE.
REQ-015 SHALL, in RD1, drive ram_addr = captured rd_row, ram_we = 0.
REQ-016 SHALL, in RD2, drive rd_valid = 1 and rd_data = ram_rdata; rd_valid zero otherwise.
REQ-017 SHALL, in WR, drive ram_we = 1, ram_addr/ram_wdata = pending row/data for exactly one cycle, then clear busy.
REQ-018 SHALL give rd_req priority over commit when both are eligible in IDLE; commit is retried next IDLE cycle.
REQ-019 SHALL ignore rd_req outside IDLE (reader waits for rd_valid before next request).
REQ-020 SHALL set refresh_image on vblank rising edge and clear it on vblank fall or on a detected write request.
REQ-021 SHALL keep ram_we = 0 in IDLE, RD1, RD2.

Reset
REQ-022 SHALL, while reset_reset is high, force FSM to IDLE and drive ram_we, rd_valid, busy, refresh_image, wr_overflow to 0, ram_addr, ram_wdata, rd_data registers to 0, and treat previous background_wr as IDLE_CODE.
REQ-023 SHALL discard any pending write and any in-flight read on reset; no RAM write occurs after reset asserts.
REQ-024 SHALL clear wr_overflow only by reset.

Configuration
REQ-025 SHALL, with macro BG_VBLANK_ONLY_EN defined, commit pending writes only while vblank = 1; a write pending at vblank fall waits for the next vblank.
REQ-026 SHALL, without BG_VBLANK_ONLY_EN, commit pending writes in any IDLE cycle without rd_req, regardless of vblank.

Verification
REQ-027 SHALL test: background_wr 1F->05 with data 32'hF00F_000F, no rd_req -> ram_we=1, ram_addr=5, ram_wdata=32'hF00F_000F within 2 cycles; busy then 0.
REQ-028 SHALL test: rd_req=1, rd_row=7, ram_rdata=32'h1234_5678 in RD2 -> rd_valid=1, rd_data=32'h1234_5678 exactly 2 cycles after rd_req.
REQ-029 SHALL test: write request and rd_req same IDLE cycle -> read completes first (RD1, RD2), ram_we=1 in following cycle.
REQ-030 SHALL test: 1F->03, 1F->09 before commit (vblank=0, BG_VBLANK_ONLY_EN defined) -> only row 9 written, at first vblank cycle; wr_overflow=1.
REQ-031 SHALL test: vblank rises -> refresh_image=1 next cycle; background_wr 1F->00 -> refresh_image=0; reset mid-WR-pending -> no ram_we, all outputs 0.
